// File: rtl/rtc_pkg.sv
// rtc_pkg: shared BCD time types, controller states and BCD helpers for the alarm bank.
package rtc_pkg;
  typedef logic [7:0] bcd_t;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  localparam bcd_t BCD_MAX_HOUR = 8'h23;
  localparam bcd_t BCD_MAX_MIN = 8'h59;
  function automatic logic bcd_valid(input bcd_t b);
    return b[7:4] <= 4'd9 && b[3:0] <= 4'd9;
  endfunction
  function automatic logic [6:0] bcd2bin(input bcd_t b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction
  function automatic bcd_t bin2bcd(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return {t[3:0], 4'(v - t * 7'd10)};
  endfunction
endpackage

// File: rtl/bcd_time_add.sv
// bcd_time_add: adds a binary minute increment to a BCD hh:mm with hour carry and 24 h wrap.
module bcd_time_add
  import rtc_pkg::*;
(
  input  bcd_t       hour,
  input  bcd_t       minute,
  input  logic [5:0] inc,
  output bcd_t       sum_hour,
  output bcd_t       sum_minute
);
  logic [6:0] m_raw, h_raw;
  logic carry;
  assign m_raw = bcd2bin(minute) + 7'(inc);
  assign carry = m_raw >= 7'd60;
  assign h_raw = bcd2bin(hour) + 7'(carry);
  assign sum_minute = bin2bcd(carry ? m_raw - 7'd60 : m_raw);
  assign sum_hour = bin2bcd(h_raw >= 7'd24 ? 7'd0 : h_raw);
endmodule

// File: rtl/rtc_alarm_bank.sv
// rtc_alarm_bank: bank of daily BCD alarms sharing one ring/snooze controller, plus hourly chime.
module rtc_alarm_bank
  import rtc_pkg::*;
#(
  parameter int N_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS = 60,
  localparam int IDX_W = N_ALARMS > 1 ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                time_valid,
  input  bcd_t                cur_hour,
  input  bcd_t                cur_minute,
  input  bcd_t                cur_second,
  input  logic                set_en,
  input  logic [IDX_W-1:0]    set_idx,
  input  bcd_t                set_hour,
  input  bcd_t                set_minute,
  input  logic                set_arm,
  input  logic                dismiss,
  input  logic                snooze,
  input  logic                chime_en,
  output logic                ring,
  output logic [IDX_W-1:0]    ring_idx,
  output logic [N_ALARMS-1:0] armed,
  output logic                set_err,
  output logic                chime_req,
  output logic [3:0]          chime_count
);
  bcd_t alarm_h [N_ALARMS];
  bcd_t alarm_m [N_ALARMS];
  bcd_t next_h [N_ALARMS];
  bcd_t next_m [N_ALARMS];
  state_t state, state_nx;
  logic [7:0] sec_cnt;
  bcd_t prev_sec, snz_h, snz_m;
  logic [N_ALARMS-1:0] match;
  logic [IDX_W-1:0] match_idx;
  logic set_ok, sec_tick, timeout, hit_ring, do_dismiss, do_snooze, enter_ring;
  logic [6:0] hour_bin;
  assign set_ok = set_en && bcd_valid(set_hour) && bcd_valid(set_minute) &&
                  set_hour <= BCD_MAX_HOUR && set_minute <= BCD_MAX_MIN && 32'(set_idx) < N_ALARMS;
  assign sec_tick = time_valid && cur_second != prev_sec;
  assign timeout = state == RINGING && sec_tick && sec_cnt == 8'(RING_SECS - 1);
  assign hit_ring = set_ok && set_idx == ring_idx && state != IDLE;
  assign enter_ring = state != RINGING && state_nx == RINGING;
  assign hour_bin = bcd2bin(cur_hour);
  bcd_time_add u_snooze_add (
    .hour      (next_h[ring_idx]),
    .minute    (next_m[ring_idx]),
    .inc       (6'(SNOOZE_MIN)),
    .sum_hour  (snz_h),
    .sum_minute(snz_m)
  );
  always_comb begin
    match = '0;
    match_idx = '0;
    for (int i = 0; i < N_ALARMS; i++)
      match[i] = time_valid && armed[i] && next_h[i] == cur_hour && next_m[i] == cur_minute && cur_second == 8'h00;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (match[i]) match_idx = IDX_W'(i);
  end
  // A set to the active channel overrides user and timeout actions; matches only count outside RINGING.
  always_comb begin
    state_nx = state;
    do_dismiss = 1'b0;
    do_snooze = 1'b0;
    if (hit_ring) state_nx = IDLE;
    else if (state == RINGING) begin
      do_dismiss = dismiss || timeout;
      do_snooze = !do_dismiss && snooze;
      state_nx = do_dismiss ? IDLE : do_snooze ? SNOOZED : RINGING;
    end else if (|match) state_nx = RINGING;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ring <= 1'b0;
      ring_idx <= '0;
      sec_cnt <= '0;
      prev_sec <= '0;
      set_err <= 1'b0;
      chime_req <= 1'b0;
      chime_count <= '0;
    end else begin
      state <= state_nx;
      ring <= state_nx == RINGING;
      ring_idx <= enter_ring ? match_idx : ring_idx;
      sec_cnt <= enter_ring ? 8'd0 : (state == RINGING && sec_tick) ? sec_cnt + 8'd1 : sec_cnt;
      prev_sec <= time_valid ? cur_second : prev_sec;
      set_err <= set_en && !set_ok;
      chime_req <= time_valid && chime_en && cur_minute == 8'h00 && cur_second == 8'h00;
      if (time_valid && chime_en && cur_minute == 8'h00 && cur_second == 8'h00)
        chime_count <= hour_bin == 7'd0 ? 4'd12 : hour_bin > 7'd12 ? 4'(hour_bin - 7'd12) : 4'(hour_bin);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        alarm_h[i] <= '0;
        alarm_m[i] <= '0;
        next_h[i] <= '0;
        next_m[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (set_ok && set_idx == IDX_W'(i)) begin
          alarm_h[i] <= set_hour;
          alarm_m[i] <= set_minute;
          next_h[i] <= set_hour;
          next_m[i] <= set_minute;
          armed[i] <= set_arm;
        end else if (do_dismiss && ring_idx == IDX_W'(i)) begin
          next_h[i] <= alarm_h[i];
          next_m[i] <= alarm_m[i];
        end else if (do_snooze && ring_idx == IDX_W'(i)) begin
          next_h[i] <= snz_h;
          next_m[i] <= snz_m;
        end
      end
    end
  end
endmodule

// File: tb/tb_rtc_alarm_bank.sv
// tb_rtc_alarm_bank: directed scenario tests for the alarm bank with hand-computed expectations.
module tb_rtc_alarm_bank;
  logic clk = 1'b0, rst = 1'b1, time_valid = 1'b0, set_en = 1'b0, set_arm = 1'b0;
  logic dismiss = 1'b0, snooze = 1'b0, chime_en = 1'b0;
  logic [7:0] cur_hour = '0, cur_minute = '0, cur_second = '0, set_hour = '0, set_minute = '0;
  logic [1:0] set_idx = '0;
  logic ring, set_err, chime_req;
  logic [1:0] ring_idx;
  logic [3:0] armed, chime_count;
  int total = 0, bad = 0;

  rtc_alarm_bank dut (
    .clk(clk), .rst(rst), .time_valid(time_valid), .cur_hour(cur_hour), .cur_minute(cur_minute),
    .cur_second(cur_second), .set_en(set_en), .set_idx(set_idx), .set_hour(set_hour),
    .set_minute(set_minute), .set_arm(set_arm), .dismiss(dismiss), .snooze(snooze),
    .chime_en(chime_en), .ring(ring), .ring_idx(ring_idx), .armed(armed), .set_err(set_err),
    .chime_req(chime_req), .chime_count(chime_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic do_set(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m, input logic arm);
    set_idx = idx; set_hour = h; set_minute = m; set_arm = arm; set_en = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  task automatic do_tv(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour = h; cur_minute = m; cur_second = s; time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
  endtask

  task automatic do_user(input logic d, input logic s);
    dismiss = d; snooze = s;
    @(negedge clk);
    dismiss = 1'b0; snooze = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_ring got %b want 0", ring); end
    total++; if (ring_idx !== 2'd0) begin bad++; $display("FAIL reset_ring_idx got %0d want 0", ring_idx); end
    total++; if (armed !== 4'b0000) begin bad++; $display("FAIL reset_armed got %b want 0000", armed); end
    total++; if (set_err !== 1'b0) begin bad++; $display("FAIL reset_set_err got %b want 0", set_err); end
    total++; if (chime_req !== 1'b0 || chime_count !== 4'd0) begin bad++; $display("FAIL reset_chime got %b/%0d want 0/0", chime_req, chime_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_set(2'd2, 8'h07, 8'h30, 1'b1);
    total++; if (armed !== 4'b0100 || set_err !== 1'b0) begin bad++; $display("FAIL basic_set got armed=%b err=%b want 0100/0", armed, set_err); end
    do_tv(8'h07, 8'h29, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL basic_early got %b want 0", ring); end
    do_tv(8'h07, 8'h30, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd2) begin bad++; $display("FAIL basic_ring got %b idx=%0d want 1 idx=2", ring, ring_idx); end
    do_user(1'b1, 1'b0);
    total++; if (ring !== 1'b0 || armed[2] !== 1'b1) begin bad++; $display("FAIL basic_dismiss got ring=%b armed2=%b want 0/1", ring, armed[2]); end
  endtask

  task automatic test_snooze;
    do_reset;
    do_set(2'd0, 8'h23, 8'h58, 1'b1);
    do_tv(8'h23, 8'h58, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd0) begin bad++; $display("FAIL snz_ring got %b idx=%0d want 1 idx=0", ring, ring_idx); end
    do_user(1'b0, 1'b1);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_stop got %b want 0", ring); end
    do_tv(8'h00, 8'h00, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_0000 got %b want 0", ring); end
    do_tv(8'h00, 8'h03, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd0) begin bad++; $display("FAIL snz_wrap got %b idx=%0d want 1 idx=0", ring, ring_idx); end
    do_user(1'b1, 1'b0);
    do_tv(8'h00, 8'h03, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_restore_old got %b want 0", ring); end
    do_tv(8'h23, 8'h58, 8'h00);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL snz_daily got %b want 1", ring); end
    do_user(1'b1, 1'b1);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_both_stop got %b want 0", ring); end
    do_tv(8'h00, 8'h03, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL snz_dismiss_wins got %b want 0", ring); end
    do_tv(8'h23, 8'h58, 8'h00);
    do_set(2'd0, 8'h23, 8'h58, 1'b1);
    total++; if (ring !== 1'b0 || armed[0] !== 1'b1) begin bad++; $display("FAIL snz_set_forces_idle got ring=%b armed0=%b want 0/1", ring, armed[0]); end
  endtask

  task automatic test_priority;
    do_reset;
    do_set(2'd1, 8'h12, 8'h00, 1'b1);
    do_set(2'd3, 8'h12, 8'h00, 1'b1);
    total++; if (armed !== 4'b1010) begin bad++; $display("FAIL pri_armed got %b want 1010", armed); end
    do_tv(8'h12, 8'h00, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd1) begin bad++; $display("FAIL pri_lowest got %b idx=%0d want 1 idx=1", ring, ring_idx); end
    do_user(1'b1, 1'b0);
    do_tv(8'h12, 8'h00, 8'h01);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL pri_drop got %b want 0", ring); end
    do_tv(8'h12, 8'h00, 8'h00);
    do_user(1'b0, 1'b1);
    do_set(2'd1, 8'h12, 8'h00, 1'b0);
    total++; if (armed !== 4'b1000) begin bad++; $display("FAIL pri_disarm got %b want 1000", armed); end
    do_tv(8'h12, 8'h05, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL pri_snooze_cancel got %b want 0", ring); end
    do_tv(8'h12, 8'h00, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd3) begin bad++; $display("FAIL pri_ch3 got %b idx=%0d want 1 idx=3", ring, ring_idx); end
    do_user(1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    int early = 0;
    do_reset;
    do_set(2'd0, 8'h07, 8'h30, 1'b1);
    do_tv(8'h07, 8'h30, 8'h00);
    for (int s = 1; s < 60; s++) begin
      do_tv(8'h07, 8'h30, to_bcd(s));
      if (ring !== 1'b1) early++;
      if (s == 10 || s == 20) begin
        do_tv(8'h07, 8'h30, to_bcd(s));
        if (ring !== 1'b1) early++;
      end
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early got %0d drops want 0", early); end
    do_tv(8'h07, 8'h31, 8'h00);
    total++; if (ring !== 1'b0 || armed[0] !== 1'b1) begin bad++; $display("FAIL to_stop got ring=%b armed0=%b want 0/1", ring, armed[0]); end
  endtask

  task automatic test_set_err_chime;
    do_reset;
    do_set(2'd1, 8'h07, 8'h00, 1'b1);
    do_set(2'd1, 8'h24, 8'h00, 1'b0);
    total++; if (set_err !== 1'b1 || armed !== 4'b0010) begin bad++; $display("FAIL err_hour got err=%b armed=%b want 1/0010", set_err, armed); end
    @(negedge clk);
    total++; if (set_err !== 1'b0) begin bad++; $display("FAIL err_pulse got %b want 0", set_err); end
    do_set(2'd2, 8'h12, 8'h5A, 1'b1);
    total++; if (set_err !== 1'b1 || armed !== 4'b0010) begin bad++; $display("FAIL err_nibble got err=%b armed=%b want 1/0010", set_err, armed); end
    do_tv(8'h07, 8'h00, 8'h00);
    total++; if (ring !== 1'b1 || ring_idx !== 2'd1) begin bad++; $display("FAIL err_kept got %b idx=%0d want 1 idx=1", ring, ring_idx); end
    do_user(1'b1, 1'b0);
    chime_en = 1'b1;
    do_set(2'd2, 8'h08, 8'h00, 1'b1);
    do_tv(8'h15, 8'h00, 8'h00);
    total++; if (chime_req !== 1'b1 || chime_count !== 4'd3) begin bad++; $display("FAIL chime_15 got %b/%0d want 1/3", chime_req, chime_count); end
    @(negedge clk);
    total++; if (chime_req !== 1'b0) begin bad++; $display("FAIL chime_pulse got %b want 0", chime_req); end
    do_tv(8'h00, 8'h00, 8'h00);
    total++; if (chime_req !== 1'b1 || chime_count !== 4'd12) begin bad++; $display("FAIL chime_00 got %b/%0d want 1/12", chime_req, chime_count); end
    do_tv(8'h15, 8'h00, 8'h01);
    total++; if (chime_req !== 1'b0) begin bad++; $display("FAIL chime_sec got %b want 0", chime_req); end
    do_tv(8'h08, 8'h00, 8'h00);
    total++; if (chime_req !== 1'b1 || chime_count !== 4'd8 || ring !== 1'b1 || ring_idx !== 2'd2) begin bad++; $display("FAIL chime_with_alarm got %b/%0d ring=%b idx=%0d want 1/8 1 2", chime_req, chime_count, ring, ring_idx); end
    do_user(1'b1, 1'b0);
    chime_en = 1'b0;
    do_tv(8'h15, 8'h00, 8'h00);
    total++; if (chime_req !== 1'b0) begin bad++; $display("FAIL chime_off got %b want 0", chime_req); end
  endtask

  task automatic test_reset_midring;
    do_reset;
    do_set(2'd0, 8'h07, 8'h30, 1'b1);
    do_tv(8'h07, 8'h30, 8'h00);
    rst = 1'b1;
    #1;
    total++; if (ring !== 1'b0 || armed !== 4'b0000) begin bad++; $display("FAIL rst_async got ring=%b armed=%b want 0/0000", ring, armed); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ring !== 1'b0 || chime_req !== 1'b0 || set_err !== 1'b0) begin bad++; $display("FAIL rst_quiet got %b%b%b want 000", ring, chime_req, set_err); end
    do_tv(8'h07, 8'h30, 8'h00);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL rst_disarmed got %b want 0", ring); end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset;
    test_basic;
    test_snooze;
    test_priority;
    test_timeout;
    test_set_err_chime;
    test_reset_midring;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_alarm_bank.md
RTC_ALARM_BANK -- requirements
Module: rtc_alarm_bank

Interface
REQ-001 Parameter N_ALARMS, default 4: number of independent alarm channels, range 1..16.
REQ-002 Parameter SNOOZE_MIN, default 5: snooze interval in minutes, range 1..59.
REQ-003 Parameter RING_SECS, default 60: auto-stop timeout in RTC second ticks, range 1..255.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 time_valid  in  1  one-cycle pulse marking a completed RTC read; cur_* valid in the same cycle.
REQ-007 cur_hour, cur_minute, cur_second  in  8 each  BCD time, 24 h format.
REQ-008 set_en  in  1  pulse; program channel set_idx.
REQ-009 set_idx  in  $clog2(N_ALARMS) (min 1)  channel to program.
REQ-010 set_hour, set_minute  in  8 each  BCD alarm time.
REQ-011 set_arm  in  1  arm (1) or disarm (0) the programmed channel.
REQ-012 dismiss, snooze  in  1 each  user pulses acting on the ringing channel.
REQ-013 chime_en  in  1  enables the hourly chime.
REQ-014 ring  out  1  high while any channel is ringing.
REQ-015 ring_idx  out  IDX_W  index of the ringing channel.
REQ-016 armed  out  N_ALARMS  per-channel armed flags.
REQ-017 set_err  out  1  one-cycle pulse on a rejected set.
REQ-018 chime_req  out  1  one-cycle pulse requesting an hourly chime.
REQ-019 chime_count  out  4  number of strikes, valid with chime_req.

Function
REQ-020 Each channel SHALL hold alarm_h/alarm_m (BCD), next_h/next_m (BCD effective trigger time), and an armed bit.
REQ-021 A set SHALL be rejected with set_err=1 and no state change if any BCD nibble >9, set_hour >0x23, set_minute >0x59, or set_idx >= N_ALARMS.
REQ-022 An accepted set SHALL load alarm_* and next_* from the set values and write armed<=set_arm; it takes effect on the next cycle.
REQ-023 A match on channel k SHALL occur on a time_valid cycle with armed[k]=1, next_h==cur_hour, next_m==cur_minute and cur_second==0x00; this gives at most one match per minute.
REQ-024 The controller FSM SHALL have states IDLE, RINGING and SNOOZED, with one shared FSM for the whole bank.
REQ-025 IDLE or SNOOZED -> RINGING on any match; the lowest matching index is latched into ring_idx.
REQ-026 Matches that occur while RINGING SHALL be dropped.
REQ-027 RINGING -> IDLE on dismiss; the channel's next_* SHALL be restored to alarm_* and armed stays 1 (daily repeat).
REQ-028 RINGING -> SNOOZED on snooze: next_* = next_* + SNOOZE_MIN in BCD.
  - Minute overflow past 59 SHALL carry into the hour.
  - Hour SHALL wrap from 23 to 00.
REQ-029 If dismiss and snooze arrive in the same cycle, dismiss SHALL win.
REQ-030 In RINGING, a second counter SHALL increment on each time_valid where cur_second differs from its previous value.
  - On reaching RING_SECS, the FSM SHALL behave exactly as for dismiss.
  - The counter SHALL clear on entry to RINGING.
REQ-031 SNOOZED -> IDLE when the snoozed channel is re-set or disarmed; SNOOZED -> RINGING on a match.
REQ-032 A set to the currently ringing channel SHALL force IDLE in the same cycle; the set wins over dismiss and snooze.
REQ-033 ring SHALL be a registered output, high exactly in RINGING, asserted the cycle after the matching time_valid.
REQ-034 chime_req SHALL pulse one cycle after a time_valid with chime_en=1, cur_minute=0x00 and cur_second=0x00.
  - chime_count = 12-hour value of cur_hour in binary.
  - 00 maps to 12; 13..23 map to 1..11.
REQ-035 Chime and alarm SHALL be independent; both may assert in the same cycle.

Reset
REQ-036 rst SHALL force FSM=IDLE, ring=0, ring_idx=0, armed=0, all alarm_*/next_*=0x00, counters=0, set_err=0, chime_req=0 and chime_count=0.
REQ-037 rst mid-ring or mid-snooze SHALL abandon the operation; no pulse SHALL follow reset release without a new time_valid.

Structure
REQ-038 A shared package rtc_pkg SHALL hold:
  - the FSM state enum;
  - the BCD byte typedef;
  - the BCD validity function;
  - constants BCD_MAX_HOUR=0x23 and BCD_MAX_MIN=0x59.
REQ-039 One sub-module, bcd_time_add, SHALL add a binary minute increment to a BCD hh:mm with carry and 24 h wrap, purely combinationally.

Verification
REQ-040 Set ch2=07:30 armed; drive time_valid at 07:30:00 -> ring=1 next cycle, ring_idx=2; then dismiss -> ring=0, armed[2]=1.
REQ-041 ch0=23:58 ringing; snooze with SNOOZE_MIN=5 -> SNOOZED; time_valid at 00:03:00 -> ring=1, ring_idx=0.
REQ-042 ch1 and ch3 both =12:00; time_valid 12:00:00 -> ring_idx=1; ch3 dropped; dismiss -> ch3 does not ring at 12:00:01.
REQ-043 Ringing with no dismiss, RING_SECS=60 -> ring falls after the 60th distinct second; repeated same-second time_valid does not advance the count.
REQ-044 Set hour 0x24 -> set_err=1, armed unchanged; time_valid 15:00:00 with chime_en=1 -> chime_req=1, chime_count=3; 00:00:00 -> chime_count=12.
REQ-045 Assert rst while RINGING -> ring=0, armed=0 immediately; no output activity until the next valid set.
